// File: rtl/ntt_demux7_scatter_if.sv
// ntt_demux7_scatter_if
//   Bundles the coefficient input handshake and the seven lane output
//   handshakes of the 1-to-7 coefficient distributor.
//   master : producer/consumer side (drives input word, select, lane readies)
//   slave  : the distributor itself
//   Signals:
//     auto_sel  1            1 = round-robin lane choice, 0 = use in_sel
//     in_valid  1            input word valid
//     in_ready  1            distributor accepts the word this cycle
//     in_data   WIDTH        coefficient
//     in_sel    3            destination lane in manual mode
//     out_valid LANES        per-lane output valid
//     out_ready LANES        per-lane consumer ready
//     out_data  LANES*WIDTH  lane i on bits [i*WIDTH +: WIDTH]
//     lane_done LANES        1-cycle pulse after a lane's BURST-th word
//     rr_ptr    3            current round-robin pointer
//     sel_err   1            sticky invalid-select flag
interface ntt_demux7_scatter_if #(
    parameter int WIDTH = 16,
    parameter int LANES = 7
);
    logic                   auto_sel;
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_data;
    logic [2:0]             in_sel;
    logic [LANES-1:0]       out_valid;
    logic [LANES-1:0]       out_ready;
    logic [LANES*WIDTH-1:0] out_data;
    logic [LANES-1:0]       lane_done;
    logic [2:0]             rr_ptr;
    logic                   sel_err;

    modport master (
        output auto_sel, in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data, lane_done, rr_ptr, sel_err
    );

    modport slave (
        input  auto_sel, in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data, lane_done, rr_ptr, sel_err
    );
endinterface

// File: rtl/ntt_demux7_scatter.sv
// ntt_demux7_scatter
//   1-to-7 coefficient distributor. Each accepted input word is written into
//   one of seven lane output registers, chosen either by in_sel or by an
//   internal round-robin pointer. Each lane has its own valid/ready toward
//   its consumer; a per-lane word counter pulses lane_done once per BURST
//   accepted words.
//   Ports:
//     clk  system clock
//     rst  synchronous active-high reset
//     bus  ntt_demux7_scatter_if.slave (input handshake, lane handshakes,
//          lane_done, rr_ptr, sel_err)
module ntt_demux7_scatter #(
    parameter int WIDTH = 16,
    parameter int LANES = 7,
    parameter int BURST = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    ntt_demux7_scatter_if.slave   bus
);
    localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [2:0] SEL_BAD = 3'd7;

    logic [LANES-1:0]       out_valid_q, out_valid_d;
    logic [LANES*WIDTH-1:0] out_data_q,  out_data_d;
    logic [LANES-1:0]       lane_done_q, lane_done_d;
    logic [CW-1:0]          cnt_q [LANES];
    logic [CW-1:0]          cnt_d [LANES];
    logic [2:0]             rr_ptr_q, rr_ptr_d;
    logic                   sel_err_q, sel_err_d;

    logic [2:0]             tgt;
    logic [7:0]             lane_free;
    logic                   in_ready;
    logic                   accept;
    logic [LANES-1:0]       load;

    // Select code 7 maps to an always-free slot: the word is taken and
    // dropped, so a bad select never stalls the input.
    assign lane_free = {1'b1, ~out_valid_q | bus.out_ready};

    always_comb begin
        tgt      = bus.auto_sel ? rr_ptr_q : bus.in_sel;
        // Held low during reset so no producer sees a completed handshake
        // for a word the reset is about to discard.
        in_ready = !rst && lane_free[tgt];
        accept   = bus.in_valid && in_ready;
        for (int unsigned i = 0; i < LANES; i++) begin
            load[i] = accept && (tgt == 3'(i));
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        lane_done_d = '0;
        rr_ptr_d    = rr_ptr_q;
        sel_err_d   = sel_err_q;
        for (int unsigned i = 0; i < LANES; i++) begin
            cnt_d[i] = cnt_q[i];
            if (load[i]) begin
                // Load wins over a same-cycle drain, giving 1 word/cycle
                // throughput on a single lane.
                out_valid_d[i]                = 1'b1;
                out_data_d[i*WIDTH +: WIDTH]  = bus.in_data;
                if (cnt_q[i] == CW'(BURST - 1)) begin
                    cnt_d[i]       = '0;
                    lane_done_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end else if (bus.out_ready[i]) begin
                // Drain only; data holds its last value.
                out_valid_d[i] = 1'b0;
            end
        end
        if (accept && bus.auto_sel) begin
            rr_ptr_d = (rr_ptr_q == 3'(LANES - 1)) ? '0 : rr_ptr_q + 3'd1;
        end
        if (accept && !bus.auto_sel && (bus.in_sel == SEL_BAD)) begin
            sel_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= '0;
            out_data_q  <= '0;
            lane_done_q <= '0;
            rr_ptr_q    <= '0;
            sel_err_q   <= 1'b0;
            for (int unsigned i = 0; i < LANES; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            lane_done_q <= lane_done_d;
            rr_ptr_q    <= rr_ptr_d;
            sel_err_q   <= sel_err_d;
            for (int unsigned i = 0; i < LANES; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.lane_done = lane_done_q;
    assign bus.rr_ptr    = rr_ptr_q;
    assign bus.sel_err   = sel_err_q;
endmodule
